// File: rtl/rgmii_rx_decode.sv
// rtl/rgmii_rx_decode.sv - RGMII DDR capture to GMII receive stream decode
// Optional in-band link status decode built when RGMII_RX_INBAND_STATUS_EN is defined.
module rgmii_rx_decode #(
    parameter int INBAND_DEBOUNCE = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] rgmii_q1,
    input  logic [4:0] rgmii_q2,
    input  logic [1:0] speed,
    output logic [7:0] gmii_rxd,
    output logic       gmii_rx_dv,
    output logic       gmii_rx_er,
    output logic       gmii_rx_valid,
    output logic       link_up,
    output logic [1:0] link_speed,
    output logic       full_duplex,
    output logic       status_change
);

    typedef enum logic [1:0] {
        IDLE_LO,
        IDLE_HI,
        FRAME_LO,
        FRAME_HI
    } state_t;

    state_t     state, state_next;
    logic [3:0] low_nib, low_nib_next;
    logic       low_er, low_er_next;
    logic [1:0] speed_q;
    logic       dv, er, nib_mode, speed_chg;
    logic [3:0] nib;
    logic       emit;
    logic [7:0] rxd_next;
    logic       dv_next, er_next;

    assign dv        = rgmii_q1[4];
    assign er        = rgmii_q1[4] ^ rgmii_q2[4];
    assign nib       = rgmii_q1[3:0];
    assign nib_mode  = ~speed[1];
    assign speed_chg = speed != speed_q;

    // Tracked through reset so that releasing reset is not seen as a speed change.
    always_ff @(posedge clk) begin
        speed_q <= speed;
    end

    always_comb begin
        state_next   = state;
        low_nib_next = low_nib;
        low_er_next  = low_er;
        emit         = 1'b0;
        rxd_next     = gmii_rxd;
        dv_next      = 1'b0;
        er_next      = 1'b0;
        if (speed_chg) begin
            state_next = IDLE_LO;
        end else if (!nib_mode) begin
            state_next = IDLE_LO;
            emit       = 1'b1;
            rxd_next   = {rgmii_q2[3:0], nib};
            dv_next    = dv;
            er_next    = er;
        end else if ((state == IDLE_LO || state == IDLE_HI) && dv) begin
            // Frame start realigns nibble pairing regardless of idle phase.
            state_next   = FRAME_HI;
            low_nib_next = nib;
            low_er_next  = er;
        end else begin
            case (state)
                IDLE_LO: begin
                    state_next   = IDLE_HI;
                    low_nib_next = nib;
                end
                IDLE_HI: begin
                    state_next = IDLE_LO;
                    emit       = 1'b1;
                    rxd_next   = {nib, low_nib};
                    er_next    = er;
                end
                FRAME_LO: begin
                    if (dv) begin
                        state_next   = FRAME_HI;
                        low_nib_next = nib;
                        low_er_next  = er;
                    end else begin
                        state_next = IDLE_LO;
                    end
                end
                default: begin
                    state_next = dv ? FRAME_LO : IDLE_LO;
                    emit       = 1'b1;
                    dv_next    = 1'b1;
                    if (dv) begin
                        rxd_next = {nib, low_nib};
                        er_next  = er | low_er;
                    end else begin
                        // Odd nibble count: flush the orphan nibble flagged as an error.
                        rxd_next = {4'h0, low_nib};
                        er_next  = 1'b1;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE_LO;
            low_nib       <= 4'h0;
            low_er        <= 1'b0;
            gmii_rxd      <= 8'h00;
            gmii_rx_dv    <= 1'b0;
            gmii_rx_er    <= 1'b0;
            gmii_rx_valid <= 1'b0;
        end else begin
            state         <= state_next;
            low_nib       <= low_nib_next;
            low_er        <= low_er_next;
            gmii_rxd      <= rxd_next;
            gmii_rx_dv    <= dv_next;
            gmii_rx_er    <= er_next;
            gmii_rx_valid <= emit;
        end
    end

`ifdef RGMII_RX_INBAND_STATUS_EN
    localparam logic [3:0] DEBOUNCE = 4'(INBAND_DEBOUNCE);

    logic [3:0] cnt, cnt_next;
    logic [3:0] last, last_next;
    logic       qual, upd;

    // Bit layout of a sample: [0]=link, [2:1]=speed, [3]=duplex.
    assign qual = !dv && !er && (rgmii_q1[3:0] == rgmii_q2[3:0]);

    always_comb begin
        cnt_next  = cnt;
        last_next = last;
        if (qual) begin
            if (nib == last && cnt != 4'd0) begin
                cnt_next = (cnt == 4'd15) ? cnt : cnt + 4'd1;
            end else begin
                cnt_next  = 4'd1;
                last_next = nib;
            end
        end
        upd = qual && (cnt_next >= DEBOUNCE) && (nib != {full_duplex, link_speed, link_up});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt           <= 4'd0;
            last          <= 4'd0;
            link_up       <= 1'b0;
            link_speed    <= 2'b00;
            full_duplex   <= 1'b0;
            status_change <= 1'b0;
        end else begin
            cnt           <= cnt_next;
            last          <= last_next;
            status_change <= upd;
            if (upd) begin
                {full_duplex, link_speed, link_up} <= nib;
            end
        end
    end
`else
    assign link_up       = 1'b0;
    assign link_speed    = 2'b00;
    assign full_duplex   = 1'b0;
    assign status_change = 1'b0;
`endif

endmodule
